// File: rtl/sd_init_sequencer.sv
// SD card SPI-mode initialisation sequencer: CMD0, CMD8, CMD55/ACMD41 polling, CMD58.
// Drives a one-shot command engine and reports done, error cause and SDHC capacity.
module sd_init_sequencer #(
  parameter int unsigned ACMD41_RETRY_MAX = 1000,
  parameter int unsigned CMD_TIMEOUT      = 4096
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        init_start,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_error,
  output logic [2:0]  error_code,
  output logic        card_sdhc,
  output logic [47:0] spi_cmd_data,
  output logic        spi_cmd,
  input  logic        spi_busy,
  input  logic        spi_error,
  input  logic [47:0] spi_response
);

  localparam int unsigned TimerW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimeoutVal = TimerW'(CMD_TIMEOUT);
  localparam logic [15:0] RetryMax = 16'(ACMD41_RETRY_MAX);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWaitAccept, StWaitDone, StEval, StDone, StFail
  } state_e;

  typedef enum logic [2:0] {
    CmdGoIdle, CmdIfCond, CmdAppCmd, CmdOpCond, CmdReadOcr
  } cmd_e;

  function automatic logic [6:0] crc7(input logic [39:0] msg);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = msg[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  function automatic logic [47:0] make_frame(input cmd_e cmd);
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [39:0] body;
    case (cmd)
      CmdGoIdle:  begin idx = 6'd0;  arg = 32'h0000_0000; end
      CmdIfCond:  begin idx = 6'd8;  arg = 32'h0000_01AA; end
      CmdAppCmd:  begin idx = 6'd55; arg = 32'h0000_0000; end
      CmdOpCond:  begin idx = 6'd41; arg = 32'h4000_0000; end
      CmdReadOcr: begin idx = 6'd58; arg = 32'h0000_0000; end
      default:    begin idx = 6'd0;  arg = 32'h0000_0000; end
    endcase
    body = {2'b01, idx, arg};
    return {body, crc7(body), 1'b1};
  endfunction

  state_e             state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic [47:0]        frame_q, frame_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [15:0]        retry_q, retry_d;
  logic [2:0]         code_q, code_d;
  logic               sdhc_q, sdhc_d;
  logic [7:0]         r1_q, r1_d;
  logic               ocr_pwr_q, ocr_pwr_d;
  logic               ccs_q, ccs_d;
  logic [11:0]        echo_q, echo_d;

  // Response bits outside R1, OCR[31:30] and the CMD8 echo carry nothing we act on.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{spi_response[37:20], spi_response[7:0]};

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    frame_d   = frame_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    code_d    = code_q;
    sdhc_d    = sdhc_q;
    r1_d      = r1_q;
    ocr_pwr_d = ocr_pwr_q;
    ccs_d     = ccs_q;
    echo_d    = echo_q;

    case (state_q)
      StIdle, StDone, StFail: begin
        if (init_start) begin
          state_d = StIssue;
          cmd_d   = CmdGoIdle;
          retry_d = '0;
          code_d  = '0;
          sdhc_d  = 1'b0;
        end
      end
      StIssue: begin
        state_d = StWaitAccept;
        timer_d = TimerW'(1);
      end
      StWaitAccept, StWaitDone: begin
        timer_d = timer_q + TimerW'(1);
        // Engine fault outranks timeout, which outranks a completing busy fall.
        if (spi_error) begin
          state_d = StFail;
          code_d  = 3'd6;
        end else if (timer_q >= TimeoutVal) begin
          state_d = StFail;
          code_d  = 3'd7;
        end else if (state_q == StWaitAccept) begin
          if (spi_busy) state_d = StWaitDone;
        end else if (!spi_busy) begin
          state_d   = StEval;
          r1_d      = spi_response[47:40];
          ocr_pwr_d = spi_response[39];
          ccs_d     = spi_response[38];
          echo_d    = spi_response[19:8];
        end
      end
      StEval: begin
        case (cmd_q)
          CmdGoIdle: begin
            if (r1_q == 8'h01) begin
              state_d = StIssue;
              cmd_d   = CmdIfCond;
            end else begin
              state_d = StFail;
              code_d  = 3'd1;
            end
          end
          CmdIfCond: begin
            if (r1_q == 8'h01 && echo_q == 12'h1AA) begin
              state_d = StIssue;
              cmd_d   = CmdAppCmd;
            end else begin
              state_d = StFail;
              code_d  = 3'd2;
            end
          end
          CmdAppCmd: begin
            if (r1_q == 8'h00 || r1_q == 8'h01) begin
              state_d = StIssue;
              cmd_d   = CmdOpCond;
            end else begin
              state_d = StFail;
              code_d  = 3'd4;
            end
          end
          CmdOpCond: begin
            if (r1_q == 8'h00) begin
              state_d = StIssue;
              cmd_d   = CmdReadOcr;
            end else if (r1_q == 8'h01) begin
              retry_d = retry_q + 16'd1;
              if (retry_d >= RetryMax) begin
                state_d = StFail;
                code_d  = 3'd3;
              end else begin
                state_d = StIssue;
                cmd_d   = CmdAppCmd;
              end
            end else begin
              state_d = StFail;
              code_d  = 3'd4;
            end
          end
          CmdReadOcr: begin
            if (r1_q == 8'h00 && ocr_pwr_q) begin
              state_d = StDone;
              sdhc_d  = ccs_q;
            end else begin
              state_d = StFail;
              code_d  = 3'd5;
            end
          end
          default: state_d = StIdle;
        endcase
      end
      default: state_d = StIdle;
    endcase

    // The frame is latched once on entry to ISSUE and stays put through the wait states.
    if (state_d == StIssue) frame_d = make_frame(cmd_d);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= StIdle;
      cmd_q     <= CmdGoIdle;
      frame_q   <= '0;
      timer_q   <= '0;
      retry_q   <= '0;
      code_q    <= '0;
      sdhc_q    <= 1'b0;
      r1_q      <= '0;
      ocr_pwr_q <= 1'b0;
      ccs_q     <= 1'b0;
      echo_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      frame_q   <= frame_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      code_q    <= code_d;
      sdhc_q    <= sdhc_d;
      r1_q      <= r1_d;
      ocr_pwr_q <= ocr_pwr_d;
      ccs_q     <= ccs_d;
      echo_q    <= echo_d;
    end
  end

  assign spi_cmd      = (state_q == StIssue);
  assign init_busy    = !(state_q == StIdle || state_q == StDone || state_q == StFail);
  assign init_done    = (state_q == StDone);
  assign init_error   = (state_q == StFail);
  assign error_code   = code_q;
  assign card_sdhc    = sdhc_q;
  assign spi_cmd_data = frame_q;

endmodule

// File: doc/sd_init_sequencer.md
SD_INIT_SEQUENCER -- requirements
Module: sd_init_sequencer

Interface
REQ-001 Parameter: ACMD41_RETRY_MAX, 1000, maximum ACMD41 attempts before failure (range 1..65535).
REQ-002 Parameter: CMD_TIMEOUT, 4096, clock cycles allowed per command from spi_cmd pulse to response (range 64..2^20).
REQ-003 Port: clk  input  1  single clock; all logic rising-edge.
REQ-004 Port: res_n  input  1  asynchronous active-low reset.
REQ-005 Port: init_start  input  1  one-cycle request to run the init sequence.
REQ-006 Port: init_busy  output  1  sequence in progress.
REQ-007 Port: init_done  output  1  card initialised; held until next init_start or reset.
REQ-008 Port: init_error  output  1  sequence failed; held until next init_start or reset.
REQ-009 Port: error_code  output  3  failure cause per REQ-022; 0 when no error.
REQ-010 Port: card_sdhc  output  1  OCR CCS bit captured from CMD58.
REQ-011 Port: spi_cmd_data  output  48  command frame to the SPI command engine.
REQ-012 Port: spi_cmd  output  1  one-cycle command strobe to the engine.
REQ-013 Port: spi_busy  input  1  engine busy.
REQ-014 Port: spi_error  input  1  engine fault flag.
REQ-015 Port: spi_response  input  48  engine response; first 0 bit (R1 MSB) at bit 47.

Function
REQ-016 Frame format SHALL be {2'b01, index[5:0], arg[31:0], crc7[6:0], 1'b1}; CRC7 (poly x^7+x^3+1, init 0) SHALL be computed over bits 47:8 by the block, not from a constant table.
REQ-017 Sequence SHALL be CMD0(arg 0) -> CMD8(arg 0x000001AA) -> [CMD55(arg 0) -> ACMD41(arg 0x40000000)] repeated -> CMD58(arg 0).
REQ-018 States SHALL be IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, EVAL, DONE, FAIL; init_start is ignored outside IDLE, DONE and FAIL.
REQ-019 Handshake: in ISSUE, spi_cmd_data SHALL be driven, spi_cmd pulsed for exactly one cycle, and spi_cmd_data held constant until EVAL; WAIT_ACCEPT exits when spi_busy=1; WAIT_DONE exits on the first cycle spi_busy=0, and spi_response is sampled in that cycle.
REQ-020 Timeout counter SHALL start at the spi_cmd pulse; reaching CMD_TIMEOUT in WAIT_ACCEPT or WAIT_DONE -> FAIL code 7.
REQ-021 EVAL rules, R1 = spi_response[47:40]:
- CMD0: R1 must be 0x01.
- CMD8: R1 must be 0x01, and [19:8] must be 12'h1AA.
- CMD55: R1 must be 0x00 or 0x01.
- ACMD41: R1=0x00 -> CMD58; R1=0x01 -> increment retry count, then CMD55, or FAIL code 3 when count reaches ACMD41_RETRY_MAX; any other value -> FAIL code 4.
- CMD58: R1 must be 0x00 and OCR bit31 (resp[39]) must be 1; card_sdhc <= resp[38]; then DONE.
REQ-022 Error codes: 1 CMD0 bad R1, 2 CMD8 bad R1 or bad echo, 3 ACMD41 retries exhausted, 4 bad R1 on CMD55/ACMD41, 5 CMD58 bad R1 or OCR not powered up, 6 spi_error=1 sampled in any WAIT state, 7 timeout.
REQ-023 Simultaneous events: spi_error takes priority over timeout; timeout takes priority over busy-fall in the same cycle.
REQ-024 init_start in DONE or FAIL SHALL clear init_done, init_error, error_code, card_sdhc and the retry count, then restart at CMD0.
REQ-025 init_busy SHALL be 1 in every state except IDLE, DONE and FAIL.

Reset
REQ-026 res_n low SHALL force IDLE asynchronously, even mid-command; spi_cmd, init_busy, init_done, init_error, card_sdhc = 0; error_code = 0; spi_cmd_data = 48'h0; counters = 0.
REQ-027 The first command after reset release SHALL be issued only on init_start.

Verification
REQ-028 Card model answers 0x01, then 0x01/echo 0x1AA, 0x01, 0x00, then 0x00 with OCR 0xC0FF8000 -> frames 40_00000000_95, 48_000001AA_87, 77_00000000_65, 69_40000000_77, 7A_00000000_FD; ends with init_done=1, card_sdhc=1.
REQ-029 ACMD41 returns 0x01 three times, then 0x00 -> four CMD55/ACMD41 pairs issued; done=1; an OCR of 0x80FF8000 gives card_sdhc=0.
REQ-030 ACMD41_RETRY_MAX=5 with ACMD41 always returning 0x01 -> exactly 5 ACMD41 frames, then init_error=1, error_code=3.
REQ-031 CMD8 echo 0x0AA -> error_code=2 and no further spi_cmd; CMD0 R1=0x05 -> error_code=1.
REQ-032 Engine never raises spi_busy -> error_code=7 after CMD_TIMEOUT cycles; spi_error=1 during CMD55 -> error_code=6.
REQ-033 res_n pulsed low during WAIT_DONE of ACMD41 -> all outputs reset values; a subsequent init_start restarts at the CMD0 frame.
